tilexy_line_drain: RTL
======================

# tileXY_line_drain

Downstream drain stage for the per-tile cache-line fifo.
- Captures each line the fifo retires on its local output (enable, 528-bit line, tile-tagged address, size/phymask, expunge flag) into a small buffer.
- Drains entries to the tile memory port as 132-bit beats under a valid/ready handshake.
- Returns a buffer-nearly-full hint, which upstream ANDs into its output enable.

## Interface
Parameters:
- DEPTH, 4: line buffer entries; power of two, 2..16.
- BEATS, 4: beats per line; beat width is 528/BEATS = 132 bits.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_en  in  1  line presented this cycle.
- in_data  in  528  line data, 66 bytes × 8.
- in_addr  in  47  {tile_Y[4:0], tile_X[4:0], addr[36:0]}.
- in_size  in  38  {shared, exclusive, phymsk[35:0]}.
- in_expun  in  1  expunge: address-only, no data.
- in_hold  out  1  buffer nearly full; upstream must not assert in_en next cycle.
- mem_valid  out  1  beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  47  line address of current entry.
- mem_size  out  38  size field of current entry.
- mem_data  out  132  current beat.
- mem_beat  out  2  beat index, 0..BEATS-1.
- mem_last  out  1  final beat of entry.
- mem_expun  out  1  current entry is an expunge.
- drop_cnt  out  8  lines dropped for empty phymask; saturates at 255.
- err_ovf  out  1  sticky: in_en seen while buffer full.

## Operation
Buffer:
- Circular FIFO with write pointer wp, read pointer rp, and count, each log2(DEPTH)+1 bits.
- Push when in_en=1 and count<DEPTH, evaluated on pre-pop count. Full blocks the push even if a pop happens the same cycle.
- in_en with count==DEPTH: line discarded, err_ovf set to 1. err_ovf clears only on reset.
- Drop rule: in_en with in_expun=0 and in_size[35:0]==0 is not pushed. drop_cnt increments, saturating at 255.
- in_hold = (count >= DEPTH-1) | (count==DEPTH-2 & push this cycle). Registered.
- Pointers wrap modulo DEPTH.

Drain FSM, states IDLE, SEND, LAST:
- IDLE: mem_valid=0. Move to SEND when count>0, with beat counter bc=0.
- SEND: mem_valid=1; mem_data=entry.data[bc*132 +: 132]; mem_beat=bc; mem_last=0.
  - On mem_ready, bc increments.
  - Move to LAST when bc reaches BEATS-1.
  - An expunge entry goes straight from IDLE to LAST: one beat, mem_data=0, mem_expun=1.
- LAST: mem_valid=1, mem_last=1. On mem_ready the entry pops (rp+1, count-1).
  - If the post-pop count >0, go to SEND with bc=0, or to LAST if the next entry is an expunge. No idle bubble.
  - Otherwise go to IDLE.
- mem_addr, mem_size and mem_expun come from the head entry and stay stable for all beats.
- While mem_valid=1 and mem_ready=0, every mem_* output holds its value.

Simultaneous push and pop: count unchanged, both pointers advance.

## Timing
- Reset values: mem_valid=0, mem_last=0, mem_beat=0, mem_expun=0, mem_addr=0, mem_size=0, mem_data=0, in_hold=0, drop_cnt=0, err_ovf=0, count=0, state IDLE. Buffer contents are not reset.
- Latency: a push at edge N gives mem_valid=1 after edge N+1, when the buffer was empty and the FSM was in IDLE.
- Throughput: one beat per cycle while mem_ready=1. A data line takes BEATS cycles; an expunge takes 1.
- Reset asserted mid-drain: all state clears asynchronously and the partially sent line is abandoned. After rst releases, outputs stay at reset values until the first push.
- in_hold reflects count at the same edge as the push/pop update, so upstream sees it one cycle later. The DEPTH-1 threshold covers that cycle.

## Test plan
- Single data line:
  - Stimulus: in_data bytes 0..65, addr 0x12_3456789A, mem_ready=1.
  - Response: 4 consecutive beats, mem_beat 0,1,2,3; beat0 = in_data[131:0]; mem_last only on beat 3; mem_valid falls the cycle after.
- Backpressure:
  - Stimulus: mem_ready toggles 1,0,0,1,... during a line.
  - Response: mem_data and mem_beat are stable through the ready=0 cycles; exactly 4 beats accepted.
- Mixed stream:
  - Stimulus: data line, expunge, data line pushed back-to-back.
  - Response: beats are 4, 1 (mem_expun=1, mem_last=1, mem_data=0), 4, with no idle cycle between entries.
- Fill and overflow:
  - Stimulus: mem_ready=0, DEPTH=4, push 5 lines.
  - Response: in_hold=1 after the 3rd push; 5th push sets err_ovf=1; release ready and exactly 4 lines drain.
- Drop and reset:
  - Stimulus: push in_size phymsk=0 with expun=0 300 times; then assert rst mid-beat 2 of a line.
  - Response: drop_cnt saturates at 255 and nothing is emitted; on reset, mem_valid=0 immediately and count=0.

Source files
------------

// File: rtl/tilexy_line_drain.sv
// Drain stage behind the per-tile cache-line fifo: buffers retired lines and
// streams them to the tile memory port as fixed-width beats under valid/ready.
module tilexy_line_drain #(
    parameter int DEPTH = 4,
    parameter int BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_en,
    input  logic [527:0]         in_data,
    input  logic [46:0]          in_addr,
    input  logic [37:0]          in_size,
    input  logic                 in_expun,
    output logic                 in_hold,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [46:0]          mem_addr,
    output logic [37:0]          mem_size,
    output logic [528/BEATS-1:0] mem_data,
    output logic [1:0]           mem_beat,
    output logic                 mem_last,
    output logic                 mem_expun,
    output logic [7:0]           drop_cnt,
    output logic                 err_ovf
);
    localparam int BW = 528 / BEATS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] NEAR     = CW'(DEPTH - 2);
    localparam logic [1:0]    LAST_BC  = 2'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, SEND, LAST} state_t;

    logic [527:0] buf_data  [DEPTH];
    logic [46:0]  buf_addr  [DEPTH];
    logic [37:0]  buf_size  [DEPTH];
    logic         buf_expun [DEPTH];

    logic [CW-1:0] wp, rp, count, rp_inc;
    state_t        state, state_d;
    logic [1:0]    bc, bc_d;
    logic          full, drop, push, pop, head_expun, next_expun;
    logic [527:0]  head_data;

    assign full       = (count == FULL);
    assign drop       = in_en & ~in_expun & (in_size[35:0] == '0);
    assign push       = in_en & ~drop & ~full;
    assign pop        = (state == LAST) & mem_ready;
    assign rp_inc     = (rp == LAST_IDX) ? '0 : rp + 1'b1;
    assign head_data  = buf_data[rp[AW-1:0]];
    assign head_expun = buf_expun[rp[AW-1:0]];
    // With one entry left, the follower is the line being pushed this very cycle.
    assign next_expun = (count > CW'(1)) ? buf_expun[rp_inc[AW-1:0]] : in_expun;

    // NOTE: the line store carries no reset; count and the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wp[AW-1:0]]  <= in_data;
            buf_addr[wp[AW-1:0]]  <= in_addr;
            buf_size[wp[AW-1:0]]  <= in_size;
            buf_expun[wp[AW-1:0]] <= in_expun;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            in_hold  <= 1'b0;
            drop_cnt <= '0;
            err_ovf  <= 1'b0;
        end else begin
            if (push) wp <= (wp == LAST_IDX) ? '0 : wp + 1'b1;
            if (pop)  rp <= rp_inc;
            count   <= count + CW'(push) - CW'(pop);
            in_hold <= (count >= LAST_IDX) | ((count == NEAR) & push);
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            if (in_en && full) err_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            bc    <= '0;
        end else begin
            state <= state_d;
            bc    <= bc_d;
        end
    end

    // NOTE: defaults come first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_d = state;
        bc_d    = bc;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    bc_d    = '0;
                    state_d = (head_expun || BEATS == 1) ? LAST : SEND;
                end
            end
            SEND: begin
                if (mem_ready) begin
                    bc_d = bc + 2'd1;
                    if (bc + 2'd1 == LAST_BC) state_d = LAST;
                end
            end
            LAST: begin
                if (mem_ready) begin
                    bc_d = '0;
                    if (count > CW'(1) || push)
                        state_d = (next_expun || BEATS == 1) ? LAST : SEND;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are zero while idle, which also gives the reset values.
    always_comb begin
        mem_valid = 1'b0;
        mem_last  = 1'b0;
        mem_beat  = '0;
        mem_expun = 1'b0;
        mem_addr  = '0;
        mem_size  = '0;
        mem_data  = '0;
        if (state != IDLE) begin
            mem_valid = 1'b1;
            mem_last  = (state == LAST);
            mem_beat  = bc;
            mem_expun = head_expun;
            mem_addr  = buf_addr[rp[AW-1:0]];
            mem_size  = buf_size[rp[AW-1:0]];
            if (!head_expun) mem_data = head_data[int'(bc)*BW +: BW];
        end
    end
endmodule
